snitch_seq_offload_arbiter: RTL
===============================

// Module: snitch_seq_offload_arbiter
// PURPOSE
// Shares one FPU sequencer offload input among NumReq requesters. It
// arbitrates round-robin and locks the grant after an FREP config so that
// the loop body of the config issuer arrives without interleaving. It
// forwards the winner index with each transfer for response routing.
// It sits between the requesters and the sequencer's inp_q* port.
// PARAMETERS
// NumReq     2   number of requesters (>=2)
// AddrWidth  32  width of argc
// DataWidth  64  width of arga/argb
// Depth      16  sequencer ring depth; DepthBits=$clog2(Depth) (derived)
// PORTS
// clk_i            in   1                  clock
// rst_ni           in   1                  async reset, active low
// inp_qvalid_i     in   NumReq             per-requester valid
// inp_qready_o     out  NumReq             per-requester ready
// inp_qid_i        in   NumReq x 5         destination register id
// inp_qdata_op_i   in   NumReq x 32        RISC-V instruction
// inp_qdata_arga_i in   NumReq x DataWidth operand a (FREP: max_rpt)
// inp_qdata_argb_i in   NumReq x DataWidth operand b
// inp_qdata_argc_i in   NumReq x AddrWidth operand c
// oup_qvalid_o     out  1                  valid to sequencer
// oup_qready_i     in   1                  sequencer ready
// oup_qid_o/op/arga/argb/argc out          muxed payload of winner
// oup_src_o        out  $clog2(NumReq)     index of the current winner
// lock_o           out  1                  high while in LOCK state
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rr_ptr=0, body_cnt=0, hold=0.
// - Purely combinational forward path. It adds 0 cycles of latency. oup_qvalid_o = inp_qvalid_i[win].
//   inp_qready_o[win] = oup_qready_i. All other readys are 0.
// - Transfer: oup_qvalid_o & oup_qready_i.
// - IDLE: win = the first valid index at or after rr_ptr, taken cyclically.
//   If no requester is valid, oup_qvalid_o=0 and oup_src_o=rr_ptr.
// - No retraction: if oup_qvalid_o=1 & oup_qready_i=0, set hold=1 and latch win.
//   While hold=1, win stays fixed until the transfer.
// - FREP detect: op[6:0]==7'b0001011 & op[14:12]==3'b000 (FREP_O/FREP_I).
// - IDLE transfer, non-FREP: rr_ptr <= win+1 (mod NumReq).
// - IDLE transfer, FREP: state <= LOCK, lock_id <= win,
//   body_cnt <= op[20+:DepthBits] (max_inst = body length - 1).
// - LOCK: win = lock_id and only that requester can get ready. FREP
//   transfers from it are forwarded and do not reload body_cnt.
// - LOCK transfer: if body_cnt==0, state <= IDLE and
//   rr_ptr <= lock_id+1. Otherwise body_cnt <= body_cnt-1.
//   A body of max_inst+1 instructions therefore releases the lock on its
//   last instruction.
// - Width: body_cnt is DepthBits wide. If max_inst=Depth-1, the body is
//   Depth instructions, with no overflow.
// - Simultaneous: a valid non-winner sees ready=0 in the same cycle.
//   rr_ptr and hold update only on the clock edge.
// - Async reset mid-LOCK or mid-hold: return to IDLE at once. There is no
//   flush of the partial body; the requesters must also reset.
// - Assertions:
//   - a payload is stable while valid is high and ready is low;
//   - NumReq>=2;
//   - DepthBits<11.
// TESTING
// 1. Req0 and req1 both stream non-FREP ops, ready=1 -> oup_src_o
//    alternates 0,1,0,1 and each transfer is one cycle.
// 2. Req1 sends FREP with max_inst=2, then 3 ops, while req0 is valid
//    throughout -> 4 consecutive req1 transfers, lock_o high for 3 cycles,
//    then req0 wins.
// 3. Req0 is valid and ready is low for 5 cycles while req1 raises valid ->
//    oup_src_o stays 0 and the payload is stable, then req0 transfers.
// 4. FREP with max_inst=15 (Depth=16) -> lock is held for exactly 16
//    body transfers and is released on the 16th.
// 5. rst_ni is pulsed low while in LOCK with body_cnt=2 -> lock_o=0 and
//    oup_qvalid_o=0 immediately. After release, arbitration resumes with
//    rr_ptr=0.
// 6. Ready toggles randomly while 3 requesters are active (NumReq=3) ->
//    no transfer is lost or duplicated and no requester starves for more
//    than NumReq grants.

Source files
------------

// File: rtl/snitch_seq_offload_arbiter_if.sv
// Offload request channel: N parallel lanes of valid/ready plus payload.
// A beat moves on a lane when qvalid and qready are both high; the master holds payload stable until then.
interface snitch_seq_offload_arbiter_if #(
    parameter int unsigned N         = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64
);
    logic [N-1:0]                qvalid;
    logic [N-1:0]                qready;
    logic [N-1:0][4:0]           qid;
    logic [N-1:0][31:0]          qdata_op;
    logic [N-1:0][DataWidth-1:0] qdata_arga;
    logic [N-1:0][DataWidth-1:0] qdata_argb;
    logic [N-1:0][AddrWidth-1:0] qdata_argc;

    modport master (
        output qvalid, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc,
        input  qready
    );

    modport slave (
        input  qvalid, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc,
        output qready
    );
endinterface

// File: rtl/snitch_seq_offload_arbiter.sv
// Round-robin arbiter in front of the FPU sequencer offload port; an FREP config
// locks the grant to its issuer until the whole loop body has been forwarded.
module snitch_seq_offload_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 16,
    localparam int unsigned DepthBits = $clog2(Depth),
    localparam int unsigned SrcWidth  = $clog2(NumReq)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    snitch_seq_offload_arbiter_if.slave         inp,
    snitch_seq_offload_arbiter_if.master        oup,
    output logic [SrcWidth-1:0]                 oup_src_o,
    output logic                                lock_o
);

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [SrcWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SrcWidth-1:0]   lock_id_q, lock_id_d;
    logic [SrcWidth-1:0]   hold_id_q, hold_id_d;
    logic                  hold_q, hold_d;
    logic [DepthBits-1:0]  body_cnt_q, body_cnt_d;

    logic [SrcWidth-1:0]   rr_win;
    logic                  rr_found;
    logic [SrcWidth-1:0]   cand;
    logic [SrcWidth-1:0]   win;
    logic                  win_valid;
    logic                  xfer;
    logic                  is_frep;

    function automatic logic [SrcWidth-1:0] next_idx(logic [SrcWidth-1:0] idx);
        return (idx == SrcWidth'(NumReq - 1)) ? '0 : idx + SrcWidth'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        rr_win   = rr_ptr_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = SrcWidth'((32'(rr_ptr_q) + i) % NumReq);
            if (!rr_found && inp.qvalid[cand]) begin
                rr_win   = cand;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        if (state_q == StLock) begin
            win = lock_id_q;
        end else if (hold_q) begin
            win = hold_id_q;
        end else begin
            win = rr_win;
        end
    end

    assign win_valid = inp.qvalid[win];
    assign xfer      = win_valid & oup.qready[0];
    assign is_frep   = (inp.qdata_op[win][6:0] == 7'b0001011) &&
                       (inp.qdata_op[win][14:12] == 3'b000);

    // Forward path is combinational; everything is forced to zero while reset is held.
    always_comb begin
        oup.qvalid     = rst_ni & win_valid;
        oup.qid        = rst_ni ? inp.qid[win]        : '0;
        oup.qdata_op   = rst_ni ? inp.qdata_op[win]   : '0;
        oup.qdata_arga = rst_ni ? inp.qdata_arga[win] : '0;
        oup.qdata_argb = rst_ni ? inp.qdata_argb[win] : '0;
        oup.qdata_argc = rst_ni ? inp.qdata_argc[win] : '0;
        inp.qready      = '0;
        inp.qready[win] = rst_ni & oup.qready[0];
    end

    assign oup_src_o = rst_ni ? win : '0;
    assign lock_o    = (state_q == StLock);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        hold_d     = hold_q;
        hold_id_d  = hold_id_q;
        body_cnt_d = body_cnt_q;
        if (state_q == StIdle) begin
            if (xfer) begin
                hold_d = 1'b0;
                if (is_frep) begin
                    state_d    = StLock;
                    lock_id_d  = win;
                    body_cnt_d = inp.qdata_op[win][20 +: DepthBits];
                end else begin
                    rr_ptr_d = next_idx(win);
                end
            end else if (win_valid) begin
                // Offered but stalled: pin the winner so the beat is never retracted.
                hold_d    = 1'b1;
                hold_id_d = win;
            end
        end else if (xfer) begin
            // body_cnt holds max_inst, so the lock drops on the last body instruction.
            if (body_cnt_q == '0) begin
                state_d  = StIdle;
                rr_ptr_d = next_idx(lock_id_q);
            end else begin
                body_cnt_d = body_cnt_q - DepthBits'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            hold_q     <= 1'b0;
            hold_id_q  <= '0;
            body_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            hold_q     <= hold_d;
            hold_id_q  <= hold_id_d;
            body_cnt_q <= body_cnt_d;
        end
    end

`ifndef SYNTHESIS
    payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (oup.qvalid[0] && !oup.qready[0]) |=>
            (oup.qvalid[0] && $stable(oup.qid) && $stable(oup.qdata_op) &&
             $stable(oup.qdata_arga) && $stable(oup.qdata_argb) && $stable(oup.qdata_argc)));
    num_req_min: assert property (@(posedge clk_i) NumReq >= 2);
    depth_bits_max: assert property (@(posedge clk_i) DepthBits < 11);
    widths_match: assert property (@(posedge clk_i)
        ($bits(oup.qdata_arga) == DataWidth) && ($bits(oup.qdata_argc) == AddrWidth));
`endif

endmodule
